// File: rtl/text_font_ram_ctrl_if.sv
// Host, fill-engine and font RAM port-A signals between the controller and its neighbours.
// No storage, so it adds no latency.
// Flow control is set by the controller: host uses hcyc/hack, fill uses busy/done.
interface text_font_ram_ctrl_if;
   // host bus
   logic        hcyc_i;
   logic        hwe_i;
   logic [3:0]  hsel_i;
   logic [13:0] hadr_i;
   logic [31:0] hdat_i;
   logic        hack_o;
   logic [31:0] hdat_o;
   // fill engine control
   logic        fill_start_i;
   logic [13:0] fill_adr_i;
   logic [13:0] fill_cnt_i;
   logic [31:0] fill_pat_i;
   logic        fill_busy_o;
   logic        fill_done_o;
   // font RAM port A
   logic        ram_cs_o;
   logic        ram_we_o;
   logic [3:0]  ram_sel_o;
   logic [13:0] ram_adr_o;
   logic [31:0] ram_dat_o;
   logic [31:0] ram_dat_i;

   modport master (
      output hcyc_i, hwe_i, hsel_i, hadr_i, hdat_i,
      output fill_start_i, fill_adr_i, fill_cnt_i, fill_pat_i,
      output ram_dat_i,
      input  hack_o, hdat_o, fill_busy_o, fill_done_o,
      input  ram_cs_o, ram_we_o, ram_sel_o, ram_adr_o, ram_dat_o
   );

   modport slave (
      input  hcyc_i, hwe_i, hsel_i, hadr_i, hdat_i,
      input  fill_start_i, fill_adr_i, fill_cnt_i, fill_pat_i,
      input  ram_dat_i,
      output hack_o, hdat_o, fill_busy_o, fill_done_o,
      output ram_cs_o, ram_we_o, ram_sel_o, ram_adr_o, ram_dat_o
   );
endinterface

// File: rtl/text_font_ram_ctrl.sv
// Arbitrates font RAM port A between the host bus and a pattern-fill engine (round robin).
// Latency: host write acks 2 clocks after grant, host read pRdLat+1; one fill word per grant.
// Backpressure: host held in HACK until hcyc_i drops; fill words interleave with host requests.
module text_font_ram_ctrl #(
   parameter int pRdLat = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   text_font_ram_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, HWR, HRD, HACK, FWR} state_t;

   localparam logic [1:0] RD_LOAD = 2'(pRdLat - 1);

   state_t      state;
   logic        last_fill;   // 1: fill had the most recent grant
   logic [1:0]  rd_cnt;
   logic [13:0] fill_ptr;
   logic [13:0] fill_left;
   logic [31:0] fill_pat;

   logic host_pend;
   logic fill_pend;
   logic grant_host;
   logic grant_fill;

   // Round-robin grant decision, only acted on while IDLE
   always_comb begin
      host_pend  = bus.hcyc_i;
      fill_pend  = bus.fill_busy_o;
      grant_host = host_pend && (!fill_pend || last_fill);
      grant_fill = fill_pend && (!host_pend || !last_fill);
   end

   // Arbiter FSM, fill engine bookkeeping and all registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= IDLE;
         last_fill       <= 1'b1;
         rd_cnt          <= '0;
         fill_ptr        <= '0;
         fill_left       <= '0;
         fill_pat        <= '0;
         bus.hack_o      <= 1'b0;
         bus.hdat_o      <= '0;
         bus.fill_busy_o <= 1'b0;
         bus.fill_done_o <= 1'b0;
         bus.ram_cs_o    <= 1'b0;
         bus.ram_we_o    <= 1'b0;
         bus.ram_sel_o   <= '0;
         bus.ram_adr_o   <= '0;
         bus.ram_dat_o   <= '0;
      end else begin
         bus.fill_done_o <= 1'b0;

         // A start is only accepted while no fill is running; zero-length fills finish at once
         if (bus.fill_start_i && !bus.fill_busy_o) begin
            if (bus.fill_cnt_i == 14'd0) begin
               bus.fill_done_o <= 1'b1;
            end else begin
               fill_ptr        <= bus.fill_adr_i;
               fill_left       <= bus.fill_cnt_i;
               fill_pat        <= bus.fill_pat_i;
               bus.fill_busy_o <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (grant_host) begin
                  last_fill     <= 1'b0;
                  bus.ram_cs_o  <= 1'b1;
                  bus.ram_sel_o <= bus.hsel_i;
                  bus.ram_adr_o <= bus.hadr_i;
                  if (bus.hwe_i) begin
                     state         <= HWR;
                     bus.ram_we_o  <= 1'b1;
                     bus.ram_dat_o <= bus.hdat_i;
                  end else begin
                     state        <= HRD;
                     bus.ram_we_o <= 1'b0;
                     rd_cnt       <= RD_LOAD;
                  end
               end else if (grant_fill) begin
                  // fill_busy_o is high here, so no start can touch the pointer this clock
                  state         <= FWR;
                  last_fill     <= 1'b1;
                  bus.ram_cs_o  <= 1'b1;
                  bus.ram_we_o  <= 1'b1;
                  bus.ram_sel_o <= 4'hF;
                  bus.ram_adr_o <= fill_ptr;
                  bus.ram_dat_o <= fill_pat;
                  fill_ptr      <= fill_ptr + 14'd1;
                  fill_left     <= fill_left - 14'd1;
               end
            end
            HWR: begin
               state        <= HACK;
               bus.ram_cs_o <= 1'b0;
               bus.ram_we_o <= 1'b0;
               bus.hack_o   <= 1'b1;
            end
            HRD: begin
               if (rd_cnt == 2'd0) begin
                  state        <= HACK;
                  bus.hdat_o   <= bus.ram_dat_i;
                  bus.ram_cs_o <= 1'b0;
                  bus.hack_o   <= 1'b1;
               end else begin
                  rd_cnt <= rd_cnt - 2'd1;
               end
            end
            HACK: begin
               // Stay until the host drops its cycle so it cannot be re-granted on a stale request
               if (!bus.hcyc_i) begin
                  state      <= IDLE;
                  bus.hack_o <= 1'b0;
               end
            end
            FWR: begin
               state        <= IDLE;
               bus.ram_cs_o <= 1'b0;
               bus.ram_we_o <= 1'b0;
               if (fill_left == 14'd0) begin
                  bus.fill_busy_o <= 1'b0;
                  bus.fill_done_o <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               bus.ram_cs_o <= 1'b0;
               bus.ram_we_o <= 1'b0;
               bus.hack_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_font_ram_ctrl.sv
// Directed bench for text_font_ram_ctrl: host write/read, fill wrap, contention, zero fill, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// A negedge monitor logs every RAM write address and counts done pulses.
module tb_text_font_ram_ctrl;
   logic clk_i;
   logic rst_ni;

   int n_checks = 0;
   int n_errors = 0;
   int cs_cnt   = 0;
   int done_cnt = 0;
   int we_wo_cs = 0;
   logic [13:0] wr_log[$];

   logic [13:0] exp_rr [6];
   int c_snap;
   int d_snap;
   bit seen;

   text_font_ram_ctrl_if bus_if();

   text_font_ram_ctrl #(.pRdLat(2)) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus_if)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(negedge clk_i) begin
      if (bus_if.ram_cs_o) cs_cnt++;
      if (bus_if.ram_we_o && !bus_if.ram_cs_o) we_wo_cs++;
      if (bus_if.ram_cs_o && bus_if.ram_we_o) wr_log.push_back(bus_if.ram_adr_o);
      if (bus_if.fill_done_o) done_cnt++;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check1({tag, "_hack"}, bus_if.hack_o, 1'b0);
      check ({tag, "_hdat"}, bus_if.hdat_o, 32'h0);
      check1({tag, "_busy"}, bus_if.fill_busy_o, 1'b0);
      check1({tag, "_done"}, bus_if.fill_done_o, 1'b0);
      check1({tag, "_cs"},   bus_if.ram_cs_o, 1'b0);
      check1({tag, "_we"},   bus_if.ram_we_o, 1'b0);
      check ({tag, "_sel"},  32'(bus_if.ram_sel_o), 32'h0);
      check ({tag, "_adr"},  32'(bus_if.ram_adr_o), 32'h0);
      check ({tag, "_dat"},  bus_if.ram_dat_o, 32'h0);
   endtask

   task automatic wait_done(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         bus_if.fill_start_i = 1'b0;
         if (bus_if.fill_done_o) begin
            got = 1'b1;
            break;
         end
      end
      check1({tag, "_done_seen"}, got, 1'b1);
      check1({tag, "_busy_after"}, bus_if.fill_busy_o, 1'b0);
   endtask

   task automatic start_fill(input logic [13:0] adr, input logic [13:0] cnt, input logic [31:0] pat);
      bus_if.fill_start_i = 1'b1;
      bus_if.fill_adr_i   = adr;
      bus_if.fill_cnt_i   = cnt;
      bus_if.fill_pat_i   = pat;
   endtask

   initial begin
      bus_if.hcyc_i       = 1'b0;
      bus_if.hwe_i        = 1'b0;
      bus_if.hsel_i       = 4'h0;
      bus_if.hadr_i       = 14'h0;
      bus_if.hdat_i       = 32'h0;
      bus_if.fill_start_i = 1'b0;
      bus_if.fill_adr_i   = 14'h0;
      bus_if.fill_cnt_i   = 14'h0;
      bus_if.fill_pat_i   = 32'h0;
      bus_if.ram_dat_i    = 32'h0;
      exp_rr = '{14'h200, 14'h100, 14'h201, 14'h101, 14'h202, 14'h102};

      // ---- reset state
      rst_ni = 1'b1;
      #3 rst_ni = 1'b0;
      tick();
      tick();
      check_zero("rst");
      rst_ni = 1'b1;
      check1("rst_rel_cs", bus_if.ram_cs_o, 1'b0);
      tick();
      check1("idle_cs", bus_if.ram_cs_o, 1'b0);

      // ---- host write: grant cycle now
      bus_if.hcyc_i = 1'b1;
      bus_if.hwe_i  = 1'b1;
      bus_if.hsel_i = 4'b0011;
      bus_if.hadr_i = 14'h0010;
      bus_if.hdat_i = 32'hA5A5_1234;
      tick();
      check1("hwr_cs",   bus_if.ram_cs_o, 1'b1);
      check1("hwr_we",   bus_if.ram_we_o, 1'b1);
      check ("hwr_sel",  32'(bus_if.ram_sel_o), 32'h3);
      check ("hwr_adr",  32'(bus_if.ram_adr_o), 32'h0010);
      check ("hwr_dat",  bus_if.ram_dat_o, 32'hA5A5_1234);
      check1("hwr_hack_early", bus_if.hack_o, 1'b0);
      tick();
      check1("hwr_hack", bus_if.hack_o, 1'b1);
      check1("hwr_ack_cs", bus_if.ram_cs_o, 1'b0);
      check1("hwr_ack_we", bus_if.ram_we_o, 1'b0);
      tick();
      check1("hwr_hack_hold", bus_if.hack_o, 1'b1);
      bus_if.hcyc_i = 1'b0;
      tick();
      check1("hwr_hack_drop", bus_if.hack_o, 1'b0);

      // ---- host read, pRdLat = 2
      bus_if.hcyc_i    = 1'b1;
      bus_if.hwe_i     = 1'b0;
      bus_if.hsel_i    = 4'hF;
      bus_if.hadr_i    = 14'h0020;
      bus_if.ram_dat_i = 32'h1111_1111;
      tick();
      check1("hrd1_cs",   bus_if.ram_cs_o, 1'b1);
      check1("hrd1_we",   bus_if.ram_we_o, 1'b0);
      check ("hrd1_adr",  32'(bus_if.ram_adr_o), 32'h0020);
      check1("hrd1_hack", bus_if.hack_o, 1'b0);
      bus_if.ram_dat_i = 32'hDEAD_BEEF;
      tick();
      check1("hrd2_cs",   bus_if.ram_cs_o, 1'b1);
      check ("hrd2_adr",  32'(bus_if.ram_adr_o), 32'h0020);
      check1("hrd2_hack", bus_if.hack_o, 1'b0);
      tick();
      check1("hrd_hack",  bus_if.hack_o, 1'b1);
      check ("hrd_hdat",  bus_if.hdat_o, 32'hDEAD_BEEF);
      check1("hrd_ack_cs", bus_if.ram_cs_o, 1'b0);
      bus_if.hcyc_i    = 1'b0;
      bus_if.ram_dat_i = 32'h0;
      tick();
      check1("hrd_hack_drop", bus_if.hack_o, 1'b0);
      check ("hrd_hdat_hold", bus_if.hdat_o, 32'hDEAD_BEEF);

      // ---- fill with address wrap
      start_fill(14'h3FFE, 14'd4, 32'h0);
      tick();
      bus_if.fill_start_i = 1'b0;
      check1("f_busy_set", bus_if.fill_busy_o, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check1($sformatf("f%0d_cs", i),  bus_if.ram_cs_o, 1'b1);
         check1($sformatf("f%0d_we", i),  bus_if.ram_we_o, 1'b1);
         check ($sformatf("f%0d_sel", i), 32'(bus_if.ram_sel_o), 32'hF);
         check ($sformatf("f%0d_adr", i), 32'(bus_if.ram_adr_o), 32'((14'h3FFE + 14'(i)) & 14'h3FFF));
         check ($sformatf("f%0d_dat", i), bus_if.ram_dat_o, 32'h0);
         tick();
         check1($sformatf("f%0d_gap_cs", i), bus_if.ram_cs_o, 1'b0);
         check1($sformatf("f%0d_busy", i), bus_if.fill_busy_o, i < 3);
         check1($sformatf("f%0d_done", i), bus_if.fill_done_o, i == 3);
      end
      tick();
      check1("f_done_single", bus_if.fill_done_o, 1'b0);
      check1("f_busy_low",    bus_if.fill_busy_o, 1'b0);

      // ---- fill of 3 under continuous host writes: H,F,H,F,H,F
      wr_log.delete();
      for (int k = 0; k < 3; k++) begin
         bus_if.hcyc_i = 1'b1;
         bus_if.hwe_i  = 1'b1;
         bus_if.hsel_i = 4'hF;
         bus_if.hadr_i = 14'h200 + 14'(k);
         bus_if.hdat_i = 32'h5000 + 32'(k);
         if (k == 0) start_fill(14'h100, 14'd3, 32'hCAFE_0000);
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            bus_if.fill_start_i = 1'b0;
            if (bus_if.hack_o) begin
               seen = 1'b1;
               break;
            end
         end
         check1($sformatf("rr_h%0d_ack", k), seen, 1'b1);
         bus_if.hcyc_i = 1'b0;
         tick();
         check1($sformatf("rr_h%0d_ack_drop", k), bus_if.hack_o, 1'b0);
      end
      wait_done("rr");
      check("rr_log_len", 32'(wr_log.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < wr_log.size())
            check($sformatf("rr_order%0d", i), 32'(wr_log[i]), 32'(exp_rr[i]));
      end

      // ---- zero-length fill, then start ignored while busy
      c_snap = cs_cnt;
      start_fill(14'h0050, 14'd0, 32'h1234);
      tick();
      bus_if.fill_start_i = 1'b0;
      check1("z_done", bus_if.fill_done_o, 1'b1);
      check1("z_busy", bus_if.fill_busy_o, 1'b0);
      tick();
      check1("z_done_single", bus_if.fill_done_o, 1'b0);
      check ("z_no_cs", 32'(cs_cnt), 32'(c_snap));

      wr_log.delete();
      start_fill(14'h0300, 14'd2, 32'h77);
      tick();
      check1("ig_busy", bus_if.fill_busy_o, 1'b1);
      start_fill(14'h03A0, 14'd9, 32'h88);
      tick();
      bus_if.fill_start_i = 1'b0;
      check("ig_dat", bus_if.ram_dat_o, 32'h77);
      wait_done("ig");
      check("ig_log_len", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check("ig_adr0", 32'(wr_log[0]), 32'h300);
         check("ig_adr1", 32'(wr_log[1]), 32'h301);
      end

      // ---- reset during word 2 of 5
      start_fill(14'h0400, 14'd5, 32'h99);
      tick();
      bus_if.fill_start_i = 1'b0;
      tick();
      check("mr_w1_adr", 32'(bus_if.ram_adr_o), 32'h400);
      tick();
      tick();
      check1("mr_w2_cs",  bus_if.ram_cs_o, 1'b1);
      check ("mr_w2_adr", 32'(bus_if.ram_adr_o), 32'h401);
      d_snap = done_cnt;
      rst_ni = 1'b0;
      #1;
      check_zero("mrst");
      tick();
      tick();
      check("mr_no_done", 32'(done_cnt), 32'(d_snap));
      rst_ni = 1'b1;
      wr_log.delete();
      start_fill(14'h0500, 14'd2, 32'h42);
      wait_done("post");
      check("post_log_len", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check("post_adr0", 32'(wr_log[0]), 32'h500);
         check("post_adr1", 32'(wr_log[1]), 32'h501);
      end
      check("post_dat", bus_if.ram_dat_o, 32'h42);

      check("we_without_cs", 32'(we_wo_cs), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
